// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and a synchronous-read
// instruction memory (slave).
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;

    modport master (output imem_addr, input imem_data);
    modport slave  (input imem_addr, output imem_data);
endinterface

// File: rtl/fetch_unit.sv
// MIPS32 instruction-fetch stage: owns the PC, drives a one-cycle-latency imem and
// presents a registered IF/ID bundle, with a one-entry hold buffer absorbing stalls.
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    fetch_unit_if.master      imem,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       oIR,
    output logic [ADDR_W-1:0] oPC,
    output logic [ADDR_W-1:0] oPC4,
    output logic              ovalid
);

    logic [ADDR_W-1:0] pc;
    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic              hold_valid;
    logic [31:0]       hold_ir;
    logic [ADDR_W-1:0] hold_pc;

    logic              hold_valid_nxt;
    logic              issue;
    logic              hold_load;
    logic [ADDR_W-1:0] target;

    // The PC register alone addresses memory, so no input reaches imem_addr combinationally.
    assign imem.imem_addr = pc;
    assign target         = redirect_pc & ~ADDR_W'(3);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hold_valid_nxt = 1'b0;
        hold_load      = 1'b0;
        if (!redirect) begin
            if (stall) begin
                hold_valid_nxt = hold_valid | req_valid;
                hold_load      = req_valid & ~hold_valid;
            end else begin
                hold_valid_nxt = hold_valid & req_valid;
                hold_load      = hold_valid & req_valid;
            end
        end
        // Issuing only into an empty hold means a response can never find the hold full.
        issue = !redirect && !hold_valid_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc         <= RESET_PC;
            req_valid  <= 1'b0;
            hold_valid <= 1'b0;
            oIR        <= '0;
            oPC        <= '0;
            oPC4       <= ADDR_W'(4);
            ovalid     <= 1'b0;
        end else begin
            hold_valid <= hold_valid_nxt;

            if (redirect) begin
                pc        <= target;
                req_valid <= 1'b0;
            end else if (issue) begin
                pc        <= pc + ADDR_W'(4);
                req_valid <= 1'b1;
            end else begin
                req_valid <= 1'b0;
            end

            // A redirect squashes whatever was about to be presented, even under stall.
            if (redirect || (!stall && !hold_valid && !req_valid)) begin
                oIR    <= '0;
                ovalid <= 1'b0;
            end else if (!stall) begin
                ovalid <= 1'b1;
                if (hold_valid) begin
                    oIR  <= hold_ir;
                    oPC  <= hold_pc;
                    oPC4 <= hold_pc + ADDR_W'(4);
                end else begin
                    oIR  <= imem.imem_data;
                    oPC  <= req_pc;
                    oPC4 <= req_pc + ADDR_W'(4);
                end
            end
        end
    end

    // NOTE: payload registers carry no reset; their valid bits gate every use of them.
    always_ff @(posedge clock) begin
        if (issue) begin
            req_pc <= pc;
        end
        if (hold_load) begin
            hold_ir <= imem.imem_data;
            hold_pc <= req_pc;
        end
    end

endmodule
